// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32 instruction-decode stage with load-use hazard detection and ID/EX register.
// Optional stall counter output enabled by ID_STALL_CNT_EN.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            id_ready,
  input  logic            ex_stall,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_rdata,
  input  logic [XLEN-1:0] rs2_rdata,
  input  logic            wb_load,
  input  logic [4:0]      wb_dest,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_ex_valid,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [4:0]      id_ex_rs1,
  output logic [4:0]      id_ex_rs2,
  output logic [XLEN-1:0] id_ex_rs1_data,
  output logic [XLEN-1:0] id_ex_rs2_data,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rd,
  output logic [6:0]      id_ex_opcode,
  output logic [2:0]      id_ex_funct3,
  output logic            id_ex_funct7b,
  output logic            id_ex_mem_read,
`ifdef ID_STALL_CNT_EN
  output logic [31:0]     stall_cnt,
`endif
  output logic            id_ex_reg_write
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm;
  logic            w_writes;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_hazard;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b;
  logic            r_mem_read;
  logic            r_reg_write;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  always_comb begin
    w_imm    = '0;
    w_writes = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_OPIMM, OP_JALR: begin
        w_imm    = {{20{if_instr[31]}}, if_instr[31:20]};
        w_writes = 1'b1;
      end
      OP_STORE:  w_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      OP_BRANCH: w_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                          if_instr[30:25], if_instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC: begin
        w_imm    = {if_instr[31:12], 12'b0};
        w_writes = 1'b1;
      end
      OP_JAL: begin
        w_imm    = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};
        w_writes = 1'b1;
      end
      OP_OP:   w_writes = 1'b1;
      default: w_writes = 1'b0;
    endcase
  end

  assign w_uses_rs1 = (w_opcode != OP_LUI) && (w_opcode != OP_AUIPC) && (w_opcode != OP_JAL);
  assign w_uses_rs2 = (w_opcode == OP_OP) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

  // Only a load sitting in ID/EX can create a hazard; ALU results are forwarded downstream.
  assign w_hazard = if_valid && r_valid && r_mem_read && (r_rd != 5'd0) &&
                    ((w_uses_rs1 && (r_rd == rs1_addr)) || (w_uses_rs2 && (r_rd == rs2_addr)));

  assign id_ready = !ex_stall && !w_hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_funct7b   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (ex_stall) begin
      // Held operands must track writebacks that land while EX is stalled.
      if (r_valid && wb_load && (wb_dest != 5'd0) && (wb_dest == r_rs1))
        r_rs1_data <= wb_data;
      if (r_valid && wb_load && (wb_dest != 5'd0) && (wb_dest == r_rs2))
        r_rs2_data <= wb_data;
    end else if (if_valid && !w_hazard) begin
      r_valid     <= 1'b1;
      r_pc        <= if_pc;
      r_rs1       <= rs1_addr;
      r_rs2       <= rs2_addr;
      r_rs1_data  <= rs1_rdata;
      r_rs2_data  <= rs2_rdata;
      r_imm       <= w_imm;
      r_rd        <= w_rd;
      r_opcode    <= w_opcode;
      r_funct3    <= if_instr[14:12];
      r_funct7b   <= if_instr[30];
      r_mem_read  <= (w_opcode == OP_LOAD);
      r_reg_write <= w_writes && (w_rd != 5'd0);
    end else begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (if_valid && !id_ready && !flush && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign id_ex_valid     = r_valid;
  assign id_ex_pc        = r_pc;
  assign id_ex_rs1       = r_rs1;
  assign id_ex_rs2       = r_rs2;
  assign id_ex_rs1_data  = r_rs1_data;
  assign id_ex_rs2_data  = r_rs2_data;
  assign id_ex_imm       = r_imm;
  assign id_ex_rd        = r_rd;
  assign id_ex_opcode    = r_opcode;
  assign id_ex_funct3    = r_funct3;
  assign id_ex_funct7b   = r_funct7b;
  assign id_ex_mem_read  = r_mem_read;
  assign id_ex_reg_write = r_reg_write;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage: expected ID/EX records queued at issue, checked when EX consumes.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b;
    logic        mem_read;
    logic        reg_write;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        ex_stall;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_rdata;
  logic [31:0] rs2_rdata;
  logic        wb_load;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc;
  logic [4:0]  id_ex_rs1;
  logic [4:0]  id_ex_rs2;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rd;
  logic [6:0]  id_ex_opcode;
  logic [2:0]  id_ex_funct3;
  logic        id_ex_funct7b;
  logic        id_ex_mem_read;
  logic        id_ex_reg_write;
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int          model_stall = 0;
`endif

  int checks = 0;
  int errors = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  // Regfile model: x0 reads 0, xN reads 0x1000+N.
  assign rs1_rdata = (rs1_addr == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, rs1_addr};
  assign rs2_rdata = (rs2_addr == 5'd0) ? 32'd0 : 32'h1000 + {27'd0, rs2_addr};

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .ex_stall(ex_stall), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
    .id_ex_rd(id_ex_rd), .id_ex_opcode(id_ex_opcode), .id_ex_funct3(id_ex_funct3),
    .id_ex_funct7b(id_ex_funct7b), .id_ex_mem_read(id_ex_mem_read),
`ifdef ID_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .id_ex_reg_write(id_ex_reg_write)
  );

  function automatic rec_t actual();
    rec_t r;
    r = '{id_ex_pc, id_ex_rs1, id_ex_rs2, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
          id_ex_rd, id_ex_opcode, id_ex_funct3, id_ex_funct7b, id_ex_mem_read, id_ex_reg_write};
    return r;
  endfunction

  // Monitor: EX consumes ID/EX whenever it is valid and not stalled.
  always @(negedge clk) begin
    if (!rst && id_ex_valid && !ex_stall) begin
      rec_t a, e;
      a = actual();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_idex got=%h", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL idex_record pc=%h got=%h want=%h", e.pc, a, e);
        end
      end
    end
`ifdef ID_STALL_CNT_EN
    if (rst) model_stall = 0;
    else if (if_valid && !id_ready && !flush) model_stall++;
`endif
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [31:0] idex_or();
    return {31'd0, id_ex_valid} | id_ex_pc | {27'd0, id_ex_rs1} | {27'd0, id_ex_rs2} |
           id_ex_rs1_data | id_ex_rs2_data | id_ex_imm | {27'd0, id_ex_rd} |
           {25'd0, id_ex_opcode} | {29'd0, id_ex_funct3} |
           {29'd0, id_ex_funct7b, id_ex_mem_read, id_ex_reg_write};
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance with if_valid dropped.
  task automatic send(input logic [31:0] pc, input logic [31:0] instr, input bit push,
                      input rec_t e, output int waits, output logic valid_at_accept);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (id_ready) break;
      waits++;
      if (waits > 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout pc=%h waits=%0d want_ready=1", pc, waits);
        break;
      end
      @(posedge clk); #1;
    end
    valid_at_accept = id_ex_valid;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  initial begin
    int   w;
    logic v;
    rst = 1'b1; ex_stall = 1'b1; flush = 1'b0; if_valid = 1'b0;
    if_pc = '0; if_instr = '0; wb_load = 1'b0; wb_dest = '0; wb_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_idex_zero", idex_or(), 32'd0);
    check("ready_while_stalled", {31'd0, id_ready}, 32'd0);
    rst = 1'b0; ex_stall = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, id_ready}, 32'd1);

    // Load ADDI into ID/EX, stall EX, then reset mid-cycle.
    send(32'h20, 32'h00500093, 1'b0, '0, w, v);
    ex_stall = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_reset_idex_zero", idex_or(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ex_stall = 1'b0;

    send(32'h40, 32'h00500093, 1'b1,
         '{32'h40, 5'd0, 5'd5, 32'h0, 32'h1005, 32'h5, 5'd1, 7'h13, 3'd0, 1'b0, 1'b0, 1'b1}, w, v);

    // LW x5,0(x2) then ADD x6,x5,x3: one stall cycle, one bubble.
    send(32'h44, 32'h00012283, 1'b1,
         '{32'h44, 5'd2, 5'd0, 32'h1002, 32'h0, 32'h0, 5'd5, 7'h03, 3'd2, 1'b0, 1'b1, 1'b1}, w, v);
    send(32'h48, 32'h00328333, 1'b1,
         '{32'h48, 5'd5, 5'd3, 32'h1005, 32'h1003, 32'h0, 5'd6, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1}, w, v);
    check("load_use_stall_cycles", w, 32'd1);
    check("load_use_bubble", {31'd0, v}, 32'd0);

    // LW x0 then ADD x6,x0,x5: no stall.
    send(32'h4c, 32'h00012003, 1'b1,
         '{32'h4c, 5'd2, 5'd0, 32'h1002, 32'h0, 32'h0, 5'd0, 7'h03, 3'd2, 1'b0, 1'b1, 1'b0}, w, v);
    send(32'h50, 32'h00500333, 1'b1,
         '{32'h50, 5'd0, 5'd5, 32'h0, 32'h1005, 32'h0, 5'd6, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1}, w, v);
    check("ld_x0_no_stall", w, 32'd0);

    // ADD x7,x1,x2 held 3 cycles while WB writes x2.
    send(32'h54, 32'h002083B3, 1'b1,
         '{32'h54, 5'd1, 5'd2, 32'h1001, 32'hDEADBEEF, 32'h0, 5'd7, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1}, w, v);
    ex_stall = 1'b1;
    wb_load = 1'b1; wb_dest = 5'd2; wb_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    wb_load = 1'b0; wb_dest = 5'd0; wb_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    ex_stall = 1'b0;

    // Flush beats ex_stall and a pending load-use hazard.
    send(32'h58, 32'h00012283, 1'b0, '0, w, v);
    ex_stall = 1'b1; flush = 1'b1;
    if_valid = 1'b1; if_pc = 32'h5c; if_instr = 32'h00328333;
    @(negedge clk);
    check("hazard_ready_low", {31'd0, id_ready}, 32'd0);
    @(posedge clk); #1;
    check("flush_valid", {31'd0, id_ex_valid}, 32'd0);
    check("flush_mem_read", {31'd0, id_ex_mem_read}, 32'd0);
    check("flush_reg_write", {31'd0, id_ex_reg_write}, 32'd0);
    flush = 1'b0; ex_stall = 1'b0;
    send(32'h5c, 32'h00328333, 1'b1,
         '{32'h5c, 5'd5, 5'd3, 32'h1005, 32'h1003, 32'h0, 5'd6, 7'h33, 3'd0, 1'b0, 1'b0, 1'b1}, w, v);
    check("post_flush_no_stall", w, 32'd0);

    // Immediate formats.
    send(32'h60, 32'hFE000CE3, 1'b1,
         '{32'h60, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFF8, 5'd25, 7'h63, 3'd0, 1'b1, 1'b0, 1'b0}, w, v);
    send(32'h64, 32'h7E312FA3, 1'b1,
         '{32'h64, 5'd2, 5'd3, 32'h1002, 32'h1003, 32'h7FF, 5'd31, 7'h23, 3'd2, 1'b1, 1'b0, 1'b0}, w, v);
    send(32'h68, 32'hABCDE537, 1'b1,
         '{32'h68, 5'd27, 5'd28, 32'h101B, 32'h101C, 32'hABCDE000, 5'd10, 7'h37, 3'd6, 1'b0, 1'b0, 1'b1}, w, v);
    send(32'h6c, 32'h001000EF, 1'b1,
         '{32'h6c, 5'd0, 5'd1, 32'h0, 32'h1001, 32'h800, 5'd1, 7'h6F, 3'd0, 1'b0, 1'b0, 1'b1}, w, v);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("bubble_when_idle", {31'd0, id_ex_valid}, 32'd0);
`ifdef ID_STALL_CNT_EN
    check("stall_cnt", stall_cnt, model_stall);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
